// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources via one-entry slots and round-robin grant.
// Latency: accepted at edge k -> rf write at edge k+1 at best, NUM_REQ cycles worst case under contention.
// Backpressure: req_ready low only while a source's slot is full and not granted; optional flush via RF_WB_ARB_FLUSH_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef RF_WB_ARB_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_input_data,
  output logic                      rf_enable,
  output logic [31:0]               pending_mask,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {EMPTY, FULL} slot_state_t;

  slot_state_t        state_q [NUM_REQ];
  slot_state_t        state_d [NUM_REQ];
  logic [ADDR_W-1:0]  slot_addr [NUM_REQ];
  logic [DATA_W-1:0]  slot_data [NUM_REQ];
  logic [NUM_REQ-1:0] load;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W:0]     cand;
  logic               gnt_vld;
  logic               flush_act;

`ifdef RF_WB_ARB_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // Search full slots starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!gnt_vld && state_q[cand[PTR_W-1:0]] == FULL) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Slot next-state; a granted slot may be refilled in the same cycle, and x0 writes never fill.
  always_comb begin
    gnt       = '0;
    req_ready = '0;
    load      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      state_d[i]   = state_q[i];
      gnt[i]       = gnt_vld && (gnt_idx == PTR_W'(i)) && !flush_act;
      req_ready[i] = !flush_act && ((state_q[i] == EMPTY) || gnt[i]);
      load[i]      = req_valid[i] && req_ready[i] && (req_addr[i*ADDR_W +: ADDR_W] != '0);
      if (flush_act)    state_d[i] = EMPTY;
      else if (load[i]) state_d[i] = FULL;
      else if (gnt[i])  state_d[i] = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) state_q[i] <= EMPTY;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) state_q[i] <= state_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      if (flush_act)    rr_ptr <= '0;
      else if (gnt_vld) rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load[i]) begin
          slot_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
          slot_data[i] <= req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rf_enable     = gnt_vld && !flush_act;
  assign rf_write_addr = rf_enable ? slot_addr[gnt_idx] : '0;
  assign rf_input_data = rf_enable ? slot_data[gnt_idx] : '0;

  always_comb begin
    pending_mask = '0;
    busy         = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q[i] == FULL) begin
        pending_mask[slot_addr[i]] = 1'b1;
        busy = 1'b1;
      end
    end
  end

endmodule
